// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - fifo-side and output-side signal bundle for fifo_rd_arbiter
interface fifo_rd_arbiter_if #(
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int BUS_WIDTH = 16
);
  logic [NCH-1:0]           ch_en;
  logic [NCH-1:0]           ch_empty_n;
  logic [NCH*BUS_WIDTH-1:0] ch_rd_data;
  logic [NCH-1:0]           ch_rd;
  logic                     out_valid;
  logic                     out_ready;
  logic [BUS_WIDTH-1:0]     out_data;
  logic [CH_W-1:0]          out_ch;

  modport master (
    input  ch_en, ch_empty_n, ch_rd_data, out_ready,
    output ch_rd, out_valid, out_data, out_ch
  );

  modport slave (
    output ch_en, ch_empty_n, ch_rd_data, out_ready,
    input  ch_rd, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin reader draining NCH one-word CDC fifos onto a valid/ready port
module fifo_rd_arbiter #(
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int BUS_WIDTH = 16,
  parameter int HOLDOFF   = 2
) (
  input  logic                rd_clk,
  input  logic                rst_n,
  fifo_rd_arbiter_if.master   bus
);

  localparam int HC_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic {IDLE, OUT} state_t;

  state_t                state, state_nxt;
  logic [CH_W-1:0]       ptr;
  logic [HC_W-1:0]       hold_cnt [NCH];
  logic [NCH-1:0]        elig;
  logic [NCH-1:0]        elig_rot;
  logic                  grant_vld;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_fire;
  logic [BUS_WIDTH-1:0]  ch_word [NCH];

  logic [NCH-1:0]        ch_rd_q;
  logic                  out_valid_q;
  logic [BUS_WIDTH-1:0]  out_data_q;
  logic [CH_W-1:0]       out_ch_q;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign ch_word[i] = bus.ch_rd_data[i*BUS_WIDTH +: BUS_WIDTH];
    assign elig[i]    = bus.ch_en[i] & bus.ch_empty_n[i] & (hold_cnt[i] == '0);
  end

  // Rotate so bit 0 is the pointer's channel; the first set bit is the grant offset.
  always_comb begin
    elig_rot  = NCH'({elig, elig} >> ptr);
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_vld && elig_rot[k]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'((int'(ptr) + k) % NCH);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          grant_fire = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      ch_rd_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) hold_cnt[i] <= '0;
    end else begin
      state   <= state_nxt;
      ch_rd_q <= '0;
      // Holdoff masks the fifo's late empty_n drop so a word is never read twice.
      for (int i = 0; i < NCH; i++) begin
        if (grant_fire && (grant_idx == CH_W'(i)))
          hold_cnt[i] <= HC_W'(HOLDOFF);
        else if (hold_cnt[i] != '0)
          hold_cnt[i] <= hold_cnt[i] - HC_W'(1);
      end
      if (grant_fire) begin
        ch_rd_q     <= NCH'(1) << grant_idx;
        out_valid_q <= 1'b1;
        out_data_q  <= ch_word[grant_idx];
        out_ch_q    <= grant_idx;
        ptr         <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + CH_W'(1);
      end else if (state == OUT && out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ch_rd     = ch_rd_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - directed self-checking bench for fifo_rd_arbiter
module tb_fifo_rd_arbiter;

  logic rd_clk = 1'b0;
  logic rst_n  = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  fifo_rd_arbiter_if #(.NCH(4), .CH_W(2), .BUS_WIDTH(16)) bus ();

  fifo_rd_arbiter #(.NCH(4), .CH_W(2), .BUS_WIDTH(16), .HOLDOFF(2)) dut (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic step();
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  task automatic set_default_data();
    for (int i = 0; i < 4; i++) bus.ch_rd_data[i*16 +: 16] = 16'hA000 + 16'(i);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.ch_en      = 4'hF;
    bus.ch_empty_n = 4'h0;
    bus.out_ready  = 1'b0;
    set_default_data();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.ch_en      = 4'hF;
    bus.ch_empty_n = 4'hF;
    bus.out_ready  = 1'b1;
    set_default_data();
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (bus.ch_rd !== 4'h0) begin
        tests_failed++;
        $display("FAIL reset_ch_rd cycle %0d: got %b expected 0000", c, bus.ch_rd);
      end
    end
    tests_run++;
    if ({bus.out_valid, bus.out_data, bus.out_ch} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d expected 0/0000/0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.ch_en               = 4'hF;
    bus.ch_empty_n          = 4'b0100;
    bus.ch_rd_data[32 +: 16] = 16'hBEEF;
    bus.out_ready           = 1'b1;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch} !== {4'b0100, 1'b1, 16'hBEEF, 2'd2}) begin
      tests_failed++;
      $display("FAIL single_grant: got rd=%b valid=%b data=%h ch=%0d expected 0100/1/beef/2",
               bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.ch_empty_n = 4'b0000;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid} !== 5'b0000_0) begin
      tests_failed++;
      $display("FAIL single_release: got rd=%b valid=%b expected 0000/0", bus.ch_rd, bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd [10];
    exp_rd = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    bus.ch_empty_n = 4'hF;
    bus.out_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if (bus.ch_rd !== exp_rd[c]) begin
        tests_failed++;
        $display("FAIL rr_ch_rd cycle %0d: got %b expected %b", c, bus.ch_rd, exp_rd[c]);
      end
      if (c % 2 == 0) begin
        tests_run++;
        if (bus.out_ch !== 2'((c / 2) % 4) || bus.out_data !== 16'hA000 + 16'((c / 2) % 4)) begin
          tests_failed++;
          $display("FAIL rr_out cycle %0d: got ch=%0d data=%h expected ch=%0d data=%h",
                   c, bus.out_ch, bus.out_data, (c / 2) % 4, 16'hA000 + 16'((c / 2) % 4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ch_empty_n = 4'b0010;
    bus.out_ready  = 1'b0;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch} !== {4'b0010, 1'b1, 16'hA001, 2'd1}) begin
      tests_failed++;
      $display("FAIL bp_grant: got rd=%b valid=%b data=%h ch=%0d expected 0010/1/a001/1",
               bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.ch_empty_n = 4'hF;
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if ({bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch} !== {4'b0000, 1'b1, 16'hA001, 2'd1}) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: got rd=%b valid=%b data=%h ch=%0d expected 0000/1/a001/1",
                 c, bus.ch_rd, bus.out_valid, bus.out_data, bus.out_ch);
      end
    end
    bus.out_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid} !== 5'b0000_0) begin
      tests_failed++;
      $display("FAIL bp_release: got rd=%b valid=%b expected 0000/0", bus.ch_rd, bus.out_valid);
    end
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_ch} !== {4'b0100, 2'd2}) begin
      tests_failed++;
      $display("FAIL bp_next_grant: got rd=%b ch=%0d expected 0100/2", bus.ch_rd, bus.out_ch);
    end
  endtask

  task automatic test_holdoff();
    int pulses;
    logic [3:0] exp_rd [6];
    exp_rd = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    bus.ch_empty_n = 4'b0010;
    bus.out_ready  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.ch_rd[1]) pulses++;
      if (c == 2) bus.ch_empty_n = 4'b0000;
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL holdoff_single_read: got %0d ch_rd[1] pulses expected 1", pulses);
    end
    do_reset();
    bus.ch_empty_n = 4'b0010;
    bus.out_ready  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++;
      if (bus.ch_rd !== exp_rd[c]) begin
        tests_failed++;
        $display("FAIL holdoff_regrant cycle %0d: got %b expected %b", c, bus.ch_rd, exp_rd[c]);
      end
    end
  endtask

  task automatic test_enable_mask();
    logic [3:0] exp_rd [8];
    exp_rd = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
    do_reset();
    bus.ch_en      = 4'b1110;
    bus.ch_empty_n = 4'hF;
    bus.out_ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      tests_run++;
      if (bus.ch_rd !== exp_rd[c]) begin
        tests_failed++;
        $display("FAIL enmask_ch_rd cycle %0d: got %b expected %b", c, bus.ch_rd, exp_rd[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.ch_empty_n = 4'hF;
    bus.out_ready  = 1'b0;
    step();
    step();
    tests_run++;
    if ({bus.out_valid, bus.out_ch} !== {1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL midrst_setup: got valid=%b ch=%0d expected 1/0", bus.out_valid, bus.out_ch);
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid, bus.out_data} !== {4'b0000, 1'b0, 16'h0000}) begin
      tests_failed++;
      $display("FAIL midrst_clear: got rd=%b valid=%b data=%h expected 0000/0/0000",
               bus.ch_rd, bus.out_valid, bus.out_data);
    end
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.ch_rd, bus.out_valid, bus.out_ch} !== {4'b0001, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL midrst_first_grant: got rd=%b valid=%b ch=%0d expected 0001/1/0",
               bus.ch_rd, bus.out_valid, bus.out_ch);
    end
  endtask

  initial begin
    bus.ch_en      = 4'h0;
    bus.ch_empty_n = 4'h0;
    bus.ch_rd_data = '0;
    bus.out_ready  = 1'b0;
    @(negedge rd_clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_holdoff();
    test_enable_mask();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Read-side scheduler that drains NCH one-word dual-clock CDC fifos, all read in the common rd_clk domain.
- Round-robin selection among channels presenting data (ch_empty_n high).
- Issues a single-cycle read strobe to the granted fifo and captures its word.
- Presents the word with its channel index on a valid/ready output toward the SDRAM command path.

Parameters:
NCH, 4, number of fifo channels (2..8)
CH_W, 2, width of channel index; NCH <= 2**CH_W
BUS_WIDTH, 16, data word width of every fifo
HOLDOFF, 2, rd_clk cycles a channel stays ineligible after its read strobe (min 1)

Ports:
rd_clk  in  1  read-domain clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
ch_en  in  NCH  per-channel enable; 0 = channel never granted
ch_empty_n  in  NCH  per-fifo "data available" flag
ch_rd_data  in  NCH*BUS_WIDTH  per-fifo read data; channel i at bits [i*BUS_WIDTH +: BUS_WIDTH]
ch_rd  out  NCH  per-fifo read strobe, one-hot, one cycle wide
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts word when high with out_valid
out_data  out  BUS_WIDTH  captured word
out_ch  out  CH_W  channel index of out_data

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on rd_clk. While rst_n is low at an edge:
  - state <= IDLE; ch_rd, out_valid, out_data, out_ch <= 0.
  - All holdoff counters <= 0; round-robin pointer <= 0 (channel 0 highest priority).
  - Reset mid-operation discards any held word. No strobe is issued during or on the cycle after reset.
- Eligibility: channel i is eligible when ch_en[i] & ch_empty_n[i] & (hold_cnt[i] == 0).
- States: IDLE, OUT.
  - IDLE, no eligible channel: remain in IDLE; ch_rd = 0.
  - IDLE, eligible set non-empty at edge N:
    - g = first eligible index searching ptr, ptr+1, ..., wrapping modulo NCH.
    - At edge N: out_data <= ch_rd_data[g]; out_ch <= g; out_valid <= 1; ch_rd <= (1 << g).
    - Also at edge N: hold_cnt[g] <= HOLDOFF; ptr <= (g+1) mod NCH (NCH-1 wraps to 0); state <= OUT.
    - Latency from sampling ch_empty_n high to out_valid/ch_rd high: 1 cycle.
  - OUT:
    - ch_rd returns to 0 at the first edge after entry; the strobe is exactly one cycle.
    - out_data, out_ch, and out_valid hold stable until the handshake.
    - out_valid & out_ready at an edge: out_valid <= 0; state <= IDLE. No new grant at that edge.
    - Maximum throughput: 1 word per 2 cycles.
- Holdoff:
  - Each nonzero hold_cnt decrements by 1 per cycle in every state, saturating at 0.
  - Purpose: covers the fifo's registered empty_n deassertion so a word is never read twice.
- Simultaneity:
  - Several eligible channels: exactly one is granted, per the pointer.
  - ch_empty_n dropping in the same cycle as the grant edge does not cancel the grant; the sampled data is used.
- ch_en deassert:
  - Blocks future grants only.
  - Does not cancel a word already in OUT.
- Invariants: ch_rd is never more than one-hot, and ch_rd is never high while rst_n is low.

Test Plan:
- Reset then single channel: ch_en=4'hF, ch_empty_n=4'b0100, ch_rd_data[2]=16'hBEEF, out_ready=1 -> ch_rd=4'b0100 for exactly 1 cycle; out_valid=1, out_data=16'hBEEF, out_ch=2, one cycle after sampling; out_valid low the cycle after that.
- Round-robin fairness: all four ch_empty_n held high, out_ready=1, HOLDOFF=2 -> grant order 0,1,2,3,0,...; one grant per 2 cycles; no channel granted twice within 4 grants.
- Backpressure: out_ready=0 for 10 cycles after a grant -> out_valid, out_data, out_ch stable; no further ch_rd pulses; word released on the first cycle out_ready=1.
- Holdoff/no double read: ch_empty_n[1] held high 2 cycles after its strobe, HOLDOFF=2 -> exactly one ch_rd[1] pulse; re-grant only after hold_cnt[1] reaches 0.
- Enable masking: ch_en=4'b1110, all ch_empty_n high -> channel 0 never strobed; order 1,2,3,1.
- Reset mid-operation: assert rst_n=0 while in OUT with out_valid=1 -> next edge out_valid=0, ch_rd=0, ptr=0; after release with all channels ready, the first grant is channel 0.
